graphic_scheduler: RTL and testbench
====================================

# graphic_scheduler

Per-scanline dispatcher that sits directly upstream of the graphic units (string, box, chart). For each display line it drives the common `dy` and fires a one-cycle `start` to each enabled unit in ascending index order. It waits for that unit's `done`, or a timeout, before moving on. It also steers the output mux select towards the line buffer and reports line and frame completion.

## Interface
- `N_UNITS`, 4: number of attached graphic units (1..16).
- `LINES`, 240: visible lines per frame; `dy` runs 0..LINES-1.
- `TIMEOUT`, 1023: maximum cycles spent in RUN per unit before forced advance.

- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `frame_start`  in  1  one-cycle pulse (vsync); starts a frame when idle.
- `line_ready`  in  1  line buffer can accept the next line.
- `unit_en`  in  N_UNITS  per-unit enable; sampled once per line.
- `done`  in  N_UNITS  per-unit one-cycle completion pulse.
- `dy`  out  12  current line index.
- `start`  out  N_UNITS  one-hot, one-cycle start pulse.
- `sel`  out  4  index of the active unit; drives the dx/wr/data mux.
- `line_done`  out  1  one-cycle pulse at the end of each line.
- `frame_done`  out  1  one-cycle pulse after line LINES-1.
- `busy`  out  1  high whenever state != IDLE.
- `timeout_err`  out  N_UNITS  sticky per-unit timeout flags.
- `overrun`  out  1  sticky; `frame_start` arrived while busy.

## Operation
- **States:** IDLE, LINE_WAIT, ISSUE, RUN, LINE_END, FRAME_END.
- **IDLE:**
  - `frame_start` -> LINE_WAIT, `dy`=0.
  - Otherwise hold.
- **LINE_WAIT:**
  - When `line_ready` is high, latch `pending` = `unit_en`.
  - If `pending` != 0: `idx` = lowest set bit, go to ISSUE.
  - Else go to LINE_END.
- **ISSUE:**
  - `start[idx]`=1 for exactly this cycle.
  - Clear the timeout counter, go to RUN.
- **RUN:** `sel`=`idx`. Each cycle:
  - `done[idx]` -> clear `pending[idx]`.
  - Else if counter == TIMEOUT -> set `timeout_err[idx]`, clear `pending[idx]`.
  - Else increment the counter.
  - On clear: if remaining `pending` != 0 -> `idx` = next lowest set bit, go to ISSUE; else go to LINE_END.
- **LINE_END:**
  - `line_done`=1.
  - If `dy` == LINES-1 -> FRAME_END.
  - Else `dy`+1, go to LINE_WAIT.
- **FRAME_END:** `frame_done`=1, `dy`=0, go to IDLE.
- **Ignored inputs:**
  - `done` bits other than `done[idx]`, and any `done` outside RUN.
  - `unit_en` changes mid-line; they take effect on the next line.
- **Simultaneous events:** `done[idx]` on the same cycle the counter hits TIMEOUT counts as done; no error is flagged.
- **`frame_start` while busy:** ignored for sequencing; sets `overrun`.
- **Sticky flags:** `timeout_err` and `overrun` clear only on `reset`.
- **Arithmetic:**
  - Timeout counter is $clog2(TIMEOUT+1) bits and saturates at TIMEOUT.
  - `dy` is 12 bits and never exceeds LINES-1; no wrap beyond it.

## Timing
- **Reset:** at the first edge with `reset`=1, all outputs go to 0: `dy`, `start`, `sel`, `line_done`, `frame_done`, `busy`, `timeout_err`, `overrun`. State goes to IDLE. Mid-operation reset aborts immediately; no `line_done`/`frame_done` is emitted.
- **Frame start to first start pulse:** `frame_start` at edge t (IDLE) -> `busy`=1 at t+1 (LINE_WAIT). With `line_ready` high at t+1, `start` is asserted at t+2.
- **Unit handoff:** `done[idx]` at edge u -> next unit's `start` at u+1, or `line_done` at u+1 if none remain.
- **Per-line overhead:** 1 LINE_WAIT + 1 ISSUE per enabled unit + 1 LINE_END cycle, plus each unit's RUN duration.
- **`sel` stability:** valid and stable from ISSUE through the last RUN cycle of that unit.
- **`dy` stability:** changes only on the LINE_END and FRAME_END exits.

## Structure
- **Package `graphic_pkg`:**
  - State enum encoding.
  - `DY_W`=12.
  - `SEL_W`=4.
  - Default LINES/TIMEOUT constants shared with the graphic units and line buffer.
- **Sub-module `graphic_prio_enc`:**
  - N_UNITS-wide lowest-set-bit finder.
  - Outputs `idx` and `valid`.
  - Used for both the first-unit and next-unit selection.

## Test plan
- **Single line, normal flow:** LINES=2, `unit_en`=4'b0101, units return `done` 5 cycles after `start`, `line_ready` tied high, `frame_start` pulse. Required: `start` sequence 0001, 0100 on each line; `dy` 0 then 1; two `line_done` pulses; one `frame_done`; `busy` low after FRAME_END.
- **Timeout:** unit 1 never asserts `done`, TIMEOUT=15. Required: `start[1]`, then exactly 16 RUN cycles, `timeout_err`=4'b0010, then advance to the next enabled unit.
- **Backpressure:** `line_ready` low for 20 cycles after `frame_start`. Required: no `start` pulse until 1 cycle after `line_ready` rises; `dy`=0 throughout.
- **Empty line:** `unit_en`=0. Required: LINE_WAIT -> LINE_END; `line_done` 2 cycles after `frame_start`; `start` never asserted.
- **Spurious inputs:**
  - `done[2]` while unit 0 is active -> ignored; unit 0 still awaited.
  - `frame_start` mid-frame -> `overrun`=1, frame unaffected.
- **Reset mid-operation:** `reset` asserted in RUN of line 3. Required: next edge all outputs 0 and IDLE; a new `frame_start` restarts at `dy`=0.

Source files
------------

// File: rtl/graphic_pkg.sv
// Shared types and constants for the graphic scheduler, graphic units and line buffer.
package graphic_pkg;

    localparam int DY_W        = 12;
    localparam int SEL_W       = 4;
    localparam int N_UNITS_DEF = 4;
    localparam int LINES_DEF   = 240;
    localparam int TIMEOUT_DEF = 1023;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LINE_WAIT,
        S_ISSUE,
        S_RUN,
        S_LINE_END,
        S_FRAME_END
    } state_t;

endpackage

// File: rtl/graphic_prio_enc.sv
// Lowest-set-bit finder used to pick the first and the next graphic unit of a line.
module graphic_prio_enc
    import graphic_pkg::*;
#(
    parameter int N = N_UNITS_DEF
) (
    input  logic [N-1:0]     req,
    output logic [SEL_W-1:0] idx,
    output logic             valid
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = SEL_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/graphic_scheduler.sv
// Per-scanline dispatcher: walks the enabled graphic units in ascending order for
// every line, waits for each unit's done (or a timeout) and reports line/frame ends.
//
// state       | meaning
// S_IDLE      | waiting for frame_start
// S_LINE_WAIT | waiting for line_ready, latches unit_en into pending
// S_ISSUE     | one-cycle start pulse to unit idx, timeout counter cleared
// S_RUN       | waiting for done[idx] or timeout
// S_LINE_END  | line_done pulse, advance dy or finish the frame
// S_FRAME_END | frame_done pulse, dy back to 0
module graphic_scheduler
    import graphic_pkg::*;
#(
    parameter int N_UNITS = N_UNITS_DEF,
    parameter int LINES   = LINES_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic               line_ready,
    input  logic [N_UNITS-1:0] unit_en,
    input  logic [N_UNITS-1:0] done,
    output logic [DY_W-1:0]    dy,
    output logic [N_UNITS-1:0] start,
    output logic [SEL_W-1:0]   sel,
    output logic               line_done,
    output logic               frame_done,
    output logic               busy,
    output logic [N_UNITS-1:0] timeout_err,
    output logic               overrun
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t             state, state_nx;
    logic [N_UNITS-1:0] pending, pending_nx;
    logic [N_UNITS-1:0] idx_mask, enc_in, terr_nx;
    logic [SEL_W-1:0]   idx, idx_nx, enc_idx;
    logic               enc_valid, unit_hit;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [DY_W-1:0]    dy_nx;

    assign idx_mask = N_UNITS'(1) << idx;

    // In LINE_WAIT the encoder looks at the fresh enables; in RUN at what is left
    // once the current unit is retired.
    assign enc_in = (state == S_LINE_WAIT) ? unit_en : (pending & ~idx_mask);

    graphic_prio_enc #(.N(N_UNITS)) u_prio_enc (
        .req   (enc_in),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    assign start      = (state == S_ISSUE) ? idx_mask : '0;
    assign sel        = idx;
    assign line_done  = (state == S_LINE_END);
    assign frame_done = (state == S_FRAME_END);
    assign busy       = (state != S_IDLE);

    // Next-state and datapath updates for the line/unit sequencing.
    always_comb begin
        state_nx   = state;
        pending_nx = pending;
        idx_nx     = idx;
        cnt_nx     = cnt;
        dy_nx      = dy;
        terr_nx    = timeout_err;
        unit_hit   = 1'b0;
        case (state)
            S_IDLE: begin
                if (frame_start) begin
                    state_nx = S_LINE_WAIT;
                    dy_nx    = '0;
                end
            end
            S_LINE_WAIT: begin
                if (line_ready) begin
                    pending_nx = unit_en;
                    if (enc_valid) begin
                        idx_nx   = enc_idx;
                        state_nx = S_ISSUE;
                    end else begin
                        state_nx = S_LINE_END;
                    end
                end
            end
            S_ISSUE: begin
                cnt_nx   = '0;
                state_nx = S_RUN;
            end
            S_RUN: begin
                // done wins over a timeout landing on the same cycle
                if (|(done & idx_mask)) begin
                    unit_hit = 1'b1;
                end else if (cnt == CNT_W'(TIMEOUT)) begin
                    terr_nx  = timeout_err | idx_mask;
                    unit_hit = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
                if (unit_hit) begin
                    pending_nx = pending & ~idx_mask;
                    if (enc_valid) begin
                        idx_nx   = enc_idx;
                        state_nx = S_ISSUE;
                    end else begin
                        state_nx = S_LINE_END;
                    end
                end
            end
            S_LINE_END: begin
                if (dy == DY_W'(LINES - 1)) begin
                    state_nx = S_FRAME_END;
                end else begin
                    dy_nx    = dy + DY_W'(1);
                    state_nx = S_LINE_WAIT;
                end
            end
            S_FRAME_END: begin
                dy_nx    = '0;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State and datapath registers; timeout_err and overrun are sticky until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            pending     <= '0;
            idx         <= '0;
            cnt         <= '0;
            dy          <= '0;
            timeout_err <= '0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_nx;
            pending     <= pending_nx;
            idx         <= idx_nx;
            cnt         <= cnt_nx;
            dy          <= dy_nx;
            timeout_err <= terr_nx;
            if (frame_start && state != S_IDLE) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_graphic_scheduler.sv
// Testbench for graphic_scheduler: each frame is planned up front as a cycle-by-cycle
// schedule derived from the line/unit timing rules, then replayed with random noise
// on the don't-care inputs while every output is compared against the plan.
module tb_graphic_scheduler;

    localparam int NU   = 4;
    localparam int NL   = 5;
    localparam int TO   = 15;
    localparam int MAXC = 2048;

    logic        clk = 1'b0;
    logic        reset, frame_start, line_ready;
    logic [3:0]  unit_en, done;
    logic [11:0] dy;
    logic [3:0]  start, sel, timeout_err;
    logic        line_done, frame_done, busy, overrun;

    int checks   = 0;
    int failures = 0;

    // planned frame schedule, one entry per clock cycle
    logic [3:0]  e_start [MAXC];
    logic [11:0] e_dy    [MAXC];
    bit          e_ld    [MAXC];
    bit          e_fd    [MAXC];
    bit          e_busy  [MAXC];
    bit          e_act   [MAXC];
    logic [3:0]  e_sel   [MAXC];
    logic [3:0]  e_dd    [MAXC];
    bit          e_run   [MAXC];
    int          e_runu  [MAXC];
    bit          e_lw    [MAXC];
    bit          e_fin   [MAXC];
    logic [3:0]  e_en    [MAXC];
    int          flen;
    int          run3;
    logic [3:0]  exp_terr;
    logic        exp_ovr;

    always #5 clk = ~clk;

    graphic_scheduler #(.N_UNITS(NU), .LINES(NL), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .line_ready  (line_ready),
        .unit_en     (unit_en),
        .done        (done),
        .dy          (dy),
        .start       (start),
        .sel         (sel),
        .line_done   (line_done),
        .frame_done  (frame_done),
        .busy        (busy),
        .timeout_err (timeout_err),
        .overrun     (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] st, input int dyv, input bit ld, input bit fd,
                        input bit bsy, input bit act, input int selv, input logic [3:0] dd,
                        input bit run, input bit lw, input bit fin, input logic [3:0] en);
        e_start[flen] = st;
        e_dy[flen]    = 12'(dyv);
        e_ld[flen]    = ld;
        e_fd[flen]    = fd;
        e_busy[flen]  = bsy;
        e_act[flen]   = act;
        e_sel[flen]   = 4'(selv);
        e_dd[flen]    = dd;
        e_run[flen]   = run;
        e_runu[flen]  = selv;
        e_lw[flen]    = lw;
        e_fin[flen]   = fin;
        e_en[flen]    = en;
        flen++;
    endtask

    // modes: 0 random, 1 en=0101 latency 5, 2 empty lines, 3 unit 1 never answers,
    //        4 random with every line non-empty, 5 random with 20 cycles of backpressure
    task automatic build_frame(input int mode);
        logic [3:0] en;
        int w, lat, rl;
        flen = 0;
        run3 = -1;
        push(4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 4'h0);
        for (int l = 0; l < NL; l++) begin
            case (mode)
                1:       en = 4'b0101;
                2:       en = 4'b0000;
                3:       en = 4'b0110;
                4:       en = 4'($urandom_range(1, 15));
                default: en = 4'($urandom_range(0, 15));
            endcase
            if (mode == 0 || mode == 4) w = $urandom_range(1, 4);
            else if (mode == 5 && l == 0) w = 21;
            else w = 1;
            for (int j = 0; j < w; j++)
                push(4'h0, l, 0, 0, 1, 0, 0, 4'h0, 0, j < w - 1, j == w - 1, en);
            for (int u = 0; u < NU; u++) begin
                if (en[u]) begin
                    if (mode == 1) lat = 5;
                    else if (mode == 3) lat = (u == 1) ? 100000 : $urandom_range(1, 6);
                    else lat = $urandom_range(1, 20);
                    rl = (lat > TO + 1) ? TO + 1 : lat;
                    if (lat > TO + 1) exp_terr[u] = 1'b1;
                    push(4'(1 << u), l, 0, 0, 1, 1, u, 4'h0, 0, 0, 0, 4'h0);
                    for (int r = 1; r <= rl; r++) begin
                        if (l == 3 && run3 < 0) run3 = flen;
                        push(4'h0, l, 0, 0, 1, 1, u, (r == lat) ? 4'(1 << u) : 4'h0, 1, 0, 0, 4'h0);
                    end
                end
            end
            push(4'h0, l, 1, 0, 1, 0, 0, 4'h0, 0, 0, 0, 4'h0);
        end
        push(4'h0, NL - 1, 0, 1, 1, 0, 0, 4'h0, 0, 0, 0, 4'h0);
        push(4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 4'h0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " dy"}, 32'(dy), 0);
        chk({tag, " start"}, 32'(start), 0);
        chk({tag, " sel"}, 32'(sel), 0);
        chk({tag, " line_done"}, 32'(line_done), 0);
        chk({tag, " frame_done"}, 32'(frame_done), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " timeout_err"}, 32'(timeout_err), 0);
        chk({tag, " overrun"}, 32'(overrun), 0);
    endtask

    task automatic run_frame(input int mode, input bit abort);
        logic [3:0] junk;
        string      t;
        build_frame(mode);
        for (int k = 0; k < flen; k++) begin
            @(posedge clk);
            #1;
            frame_start = (k == 0) || (e_busy[k] && $urandom_range(0, 15) == 0);
            if (k != 0 && frame_start) exp_ovr = 1'b1;
            line_ready = e_lw[k] ? 1'b0 : (e_fin[k] ? 1'b1 : 1'($urandom_range(0, 1)));
            unit_en    = e_fin[k] ? e_en[k] : 4'($urandom);
            junk       = 4'($urandom & $urandom & $urandom);
            if (e_run[k]) junk[e_runu[k]] = 1'b0;
            done  = junk | e_dd[k];
            reset = abort && (k == run3);
            @(negedge clk);
            t = $sformatf("m%0d c%0d", mode, k);
            chk({t, " start"}, 32'(start), 32'(e_start[k]));
            chk({t, " dy"}, 32'(dy), 32'(e_dy[k]));
            chk({t, " line_done"}, 32'(line_done), 32'(e_ld[k]));
            chk({t, " frame_done"}, 32'(frame_done), 32'(e_fd[k]));
            chk({t, " busy"}, 32'(busy), 32'(e_busy[k]));
            if (e_act[k]) chk({t, " sel"}, 32'(sel), 32'(e_sel[k]));
            if (reset) begin
                @(posedge clk);
                #1;
                reset       = 1'b0;
                frame_start = 1'b0;
                done        = 4'h0;
                @(negedge clk);
                check_all_zero("after_mid_reset");
                exp_terr = 4'h0;
                exp_ovr  = 1'b0;
                return;
            end
        end
        chk($sformatf("m%0d timeout_err", mode), 32'(timeout_err), 32'(exp_terr));
        chk($sformatf("m%0d overrun", mode), 32'(overrun), 32'(exp_ovr));
    endtask

    initial begin
        reset       = 1'b1;
        frame_start = 1'b0;
        line_ready  = 1'b0;
        unit_en     = 4'h0;
        done        = 4'h0;
        exp_terr    = 4'h0;
        exp_ovr     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_frame(1, 1'b0);
        run_frame(2, 1'b0);
        run_frame(3, 1'b0);
        run_frame(5, 1'b0);
        for (int i = 0; i < 6; i++) run_frame(0, 1'b0);
        run_frame(4, 1'b1);
        run_frame(0, 1'b0);
        run_frame(4, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
